// File: rtl/temp_sensor_reader.sv
// Temperature sensor front-end: polls a read-only 3-wire serial sensor, shifts in
// an MSB-first frame, saturates it to 5 bits and presents it with a valid strobe.
module temp_sensor_reader #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned POLL_CYCLES = 1000,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned RESET_TEMP  = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       force_read,
    input  logic       sensor_miso,
    output logic       sensor_cs_n,
    output logic       sensor_sclk,
    output logic [4:0] temperature,
    output logic       temp_valid,
    output logic       temp_sat,
    output logic       busy
);

    localparam int unsigned TimerW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
    localparam int unsigned DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HalfW  = $clog2(2 * DATA_BITS);

    localparam logic [TimerW-1:0]    TimerLast = TimerW'(POLL_CYCLES - 1);
    localparam logic [DivW-1:0]      DivLast   = DivW'(CLK_DIV - 1);
    localparam logic [HalfW-1:0]     HalfLast  = HalfW'(2 * DATA_BITS - 1);
    localparam logic [DATA_BITS-1:0] TempMax   = DATA_BITS'(31);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StDone} state_e;

    state_e                 state_q, state_d;
    logic [TimerW-1:0]      timer_q, timer_d;
    logic [DivW-1:0]        div_q, div_d;
    logic [HalfW-1:0]       half_q, half_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   cs_n_q, cs_n_d;
    logic                   sclk_q, sclk_d;
    logic [4:0]             temp_q, temp_d;
    logic                   sat_q, sat_d;
    logic                   valid_q, valid_d;
    logic                   busy_q, busy_d;
    logic                   over;

    assign over = (shift_q > TempMax);

    // Next-state and registered-output computation for the polling sequencer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        div_d   = div_q;
        half_d  = half_q;
        shift_d = shift_q;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        temp_d  = temp_q;
        sat_d   = sat_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        unique case (state_q)
            StIdle: begin
                // Expiry and force in the same cycle still start just one conversion.
                if (timer_q == TimerLast || force_read) begin
                    state_d = StSetup;
                    timer_d = '0;
                    div_d   = '0;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StSetup: begin
                if (div_q == DivLast) begin
                    state_d = StShift;
                    div_d   = '0;
                    half_d  = '0;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StShift: begin
                if (div_q == DivLast) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // Sample on the edge that raises sclk.
                    if (!sclk_q) begin
                        shift_d = {shift_q[DATA_BITS-2:0], sensor_miso};
                    end
                    if (half_q == HalfLast) begin
                        // Last half-period ends with sclk falling; frame is complete.
                        state_d = StDone;
                        cs_n_d  = 1'b1;
                        sclk_d  = 1'b0;
                        temp_d  = over ? 5'd31 : shift_q[4:0];
                        sat_d   = over;
                        valid_d = 1'b1;
                    end else begin
                        half_d = half_q + 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
                timer_d = '0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            timer_q <= '0;
            div_q   <= '0;
            half_q  <= '0;
            shift_q <= '0;
            cs_n_q  <= 1'b1;
            sclk_q  <= 1'b0;
            temp_q  <= 5'(RESET_TEMP);
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            div_q   <= div_d;
            half_q  <= half_d;
            shift_q <= shift_d;
            cs_n_q  <= cs_n_d;
            sclk_q  <= sclk_d;
            temp_q  <= temp_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign sensor_cs_n = cs_n_q;
    assign sensor_sclk = sclk_q;
    assign temperature = temp_q;
    assign temp_sat    = sat_q;
    assign temp_valid  = valid_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Bench for temp_sensor_reader: behavioural sensor, scoreboard of expected readings,
// frame-shape monitor and directed timing scenarios plus randomized frames.
module tb_temp_sensor_reader;

    localparam int unsigned CLK_DIV     = 2;
    localparam int unsigned POLL_CYCLES = 20;
    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned RESET_TEMP  = 20;
    localparam int FRAME_LOW = CLK_DIV + 2 * CLK_DIV * DATA_BITS;
    localparam int PERIOD    = POLL_CYCLES + FRAME_LOW + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       force_read = 1'b0;
    logic       sensor_miso = 1'b0;
    logic       sensor_cs_n;
    logic       sensor_sclk;
    logic [4:0] temperature;
    logic       temp_valid;
    logic       temp_sat;
    logic       busy;

    typedef struct {
        int temp;
        int sat;
    } exp_t;

    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    int   words[$];
    exp_t exp_q[$];
    int   cur_word = 0;
    int   bit_idx = 0;

    temp_sensor_reader #(
        .CLK_DIV    (CLK_DIV),
        .POLL_CYCLES(POLL_CYCLES),
        .DATA_BITS  (DATA_BITS),
        .RESET_TEMP (RESET_TEMP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .force_read (force_read),
        .sensor_miso(sensor_miso),
        .sensor_cs_n(sensor_cs_n),
        .sensor_sclk(sensor_sclk),
        .temperature(temperature),
        .temp_valid (temp_valid),
        .temp_sat   (temp_sat),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    function automatic exp_t model(input int w);
        exp_t e;
        e.temp = (w > 31) ? 31 : w;
        e.sat  = (w > 31) ? 1 : 0;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act == req) passed++;
        else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    endtask

    // Sensor: presents MSB when selected, next bit after every falling sclk.
    initial forever begin
        @(negedge sensor_cs_n);
        if (words.size() > 0) cur_word = words.pop_front();
        else cur_word = int'($urandom_range(0, 255));
        exp_q.push_back(model(cur_word));
        bit_idx = DATA_BITS - 1;
        sensor_miso = cur_word[bit_idx];
    end

    initial forever begin
        @(negedge sensor_sclk);
        if (!sensor_cs_n && bit_idx > 0) begin
            bit_idx = bit_idx - 1;
            sensor_miso = cur_word[bit_idx];
        end
    end

    // Monitor: scoreboard pops on valid, plus per-cycle and per-frame shape checks.
    initial begin
        logic       prev_cs;
        logic       prev_sclk;
        logic       prev_valid;
        logic [4:0] prev_temp;
        int         low_cnt;
        int         rise_cnt;
        exp_t       e;
        prev_cs = 1'b1; prev_sclk = 1'b0; prev_valid = 1'b0; prev_temp = 5'd0;
        low_cnt = 0; rise_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_cs = 1'b1; prev_sclk = 1'b0; prev_valid = 1'b0;
                prev_temp = temperature; low_cnt = 0; rise_cnt = 0;
            end else begin
                check("busy", int'(busy), int'(!sensor_cs_n || temp_valid));
                if (!temp_valid) check("temp_hold", int'(temperature), int'(prev_temp));
                if (temp_valid) begin
                    check("valid_width", int'(prev_valid), 0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", int'(temp_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("temperature", int'(temperature), e.temp);
                        check("temp_sat", int'(temp_sat), e.sat);
                    end
                end
                if (!sensor_cs_n) begin
                    low_cnt++;
                    if (sensor_sclk && !prev_sclk) rise_cnt++;
                end
                if (sensor_cs_n && !prev_cs) begin
                    check("cs_low_cycles", low_cnt, FRAME_LOW);
                    check("sclk_rises", rise_cnt, DATA_BITS);
                    check("sclk_idle", int'(sensor_sclk), 0);
                    low_cnt = 0;
                    rise_cnt = 0;
                end
                prev_cs = sensor_cs_n;
                prev_sclk = sensor_sclk;
                prev_valid = temp_valid;
                prev_temp = temperature;
            end
        end
    end

    task automatic wait_valid(output int c);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!temp_valid && n < 300);
        if (!temp_valid) check("valid_timeout", int'(temp_valid), 1);
        c = cyc;
    endtask

    // Counts rising clk edges until cs_n is seen low.
    task automatic cycles_to_cs_low(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (sensor_cs_n && n < 200);
        if (sensor_cs_n) check("cs_timeout", int'(sensor_cs_n), 0);
    endtask

    initial begin
        int n;
        int c1;
        int c2;
        int c3;

        repeat (3) @(negedge clk);
        check("rst_cs_n", int'(sensor_cs_n), 1);
        check("rst_sclk", int'(sensor_sclk), 0);
        check("rst_temp", int'(temperature), RESET_TEMP);
        check("rst_valid", int'(temp_valid), 0);
        check("rst_sat", int'(temp_sat), 0);
        check("rst_busy", int'(busy), 0);

        // Plain reading, then saturating and boundary readings.
        words.push_back('h17);
        words.push_back('h40);
        words.push_back('h1F);
        rst = 1'b1;
        cycles_to_cs_low(n);
        check("first_start", n, POLL_CYCLES);
        wait_valid(c1);
        check("first_temp", int'(temperature), 23);
        cycles_to_cs_low(n);
        check("poll_gap", n, POLL_CYCLES + 1);
        wait_valid(c1);
        wait_valid(c1);
        check("boundary_sat", int'(temp_sat), 0);

        // Forced read in idle; a second force during SHIFT must be ignored.
        words.push_back('h05);
        repeat (5) @(posedge clk);
        @(negedge clk);
        force_read = 1'b1;
        @(posedge clk);
        #1;
        force_read = 1'b0;
        check("force_start", int'(sensor_cs_n), 0);
        repeat (CLK_DIV + 8) @(posedge clk);
        #1 force_read = 1'b1;
        repeat (2) @(posedge clk);
        #1 force_read = 1'b0;
        wait_valid(c1);
        cycles_to_cs_low(n);
        check("no_queued_force", n, POLL_CYCLES + 1);

        // Reset in the middle of SHIFT aborts the frame.
        repeat (CLK_DIV + 10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_cs_n", int'(sensor_cs_n), 1);
        check("abort_sclk", int'(sensor_sclk), 0);
        check("abort_temp", int'(temperature), RESET_TEMP);
        check("abort_valid", int'(temp_valid), 0);
        check("abort_busy", int'(busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        cycles_to_cs_low(n);
        check("restart_start", n, POLL_CYCLES);
        wait_valid(c1);

        // Free-running with constant zero readings.
        words.push_back(0);
        words.push_back(0);
        words.push_back(0);
        wait_valid(c1);
        wait_valid(c2);
        wait_valid(c3);
        check("period_1", c2 - c1, PERIOD);
        check("period_2", c3 - c2, PERIOD);
        check("zero_temp", int'(temperature), 0);

        // Force coinciding with timer expiry starts one conversion only.
        repeat (POLL_CYCLES) @(posedge clk);
        #1;
        check("pre_expiry_idle", int'(sensor_cs_n), 1);
        force_read = 1'b1;
        @(posedge clk);
        #1;
        force_read = 1'b0;
        check("expiry_force_start", int'(sensor_cs_n), 0);
        wait_valid(c1);
        cycles_to_cs_low(n);
        check("expiry_single", n, POLL_CYCLES + 1);
        wait_valid(c1);

        // Randomized readings with occasional forced reads at random idle points.
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, POLL_CYCLES + 2)) @(posedge clk);
            #1 force_read = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1 force_read = 1'b0;
            wait_valid(c1);
        end

        @(negedge clk);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
